// File: rtl/pipe_credit_sink.sv
// rtl/pipe_credit_sink.sv - credit-gated show-ahead FIFO sink for a free-running valid-tagged pipeline (optional PIPE_CREDIT_SINK_ERR_EN)
module pipe_credit_sink #(
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 10,
    parameter int DEPTH      = 16
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic                               src_valid_in,
    output logic                               src_ready_out,
    input  logic signed [DATA_WIDTH-1:0]       pipe_data_in,
    input  logic                               pipe_valid_in,
    output logic signed [DATA_WIDTH-1:0]       dst_data_out,
    output logic                               dst_valid_out,
    input  logic                               dst_ready_in,
    output logic [$clog2(DEPTH+1)-1:0]         level_out,
    output logic [1:0]                         err_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W:0]   committed;
    logic             accept;
    logic             pop;
    logic             full;
    logic             wr_en;

    // Credits count both stored and still-travelling samples; registers only, so no loop through src_valid_in or dst_ready_in.
    assign committed     = {1'b0, occupancy} + {1'b0, inflight};
    assign src_ready_out = committed < {1'b0, DEPTH_C};
    assign accept        = src_valid_in && src_ready_out;
    assign dst_valid_out = occupancy != '0;
    assign pop           = dst_valid_out && dst_ready_in;
    assign full          = occupancy == DEPTH_C;
    assign wr_en         = pipe_valid_in && (!full || pop);
    assign rd_next       = rd_ptr + PTR_ONE;
    assign level_out     = occupancy;

    // Samples accepted upstream but not yet emerged from the pipeline; saturates at zero on a spurious arrival.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            inflight <= '0;
        end else if (accept && !pipe_valid_in) begin
            inflight <= inflight + CNT_ONE;
        end else if (pipe_valid_in && !accept && inflight != '0) begin
            inflight <= inflight - CNT_ONE;
        end
    end

    // Storage array; contents are only meaningful between rd_ptr and wr_ptr, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= pipe_data_in;
        end
    end

    // Pointer and occupancy bookkeeping; a write and a pop together leave occupancy unchanged.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (wr_en && !pop) begin
                occupancy <= occupancy + CNT_ONE;
            end else if (pop && !wr_en) begin
                occupancy <= occupancy - CNT_ONE;
            end
        end
    end

    // Registered head: the entry behind the popped one, or the incoming sample when it becomes the only entry.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dst_data_out <= '0;
        end else if (pop) begin
            if (occupancy == CNT_ONE) begin
                if (wr_en) begin
                    dst_data_out <= pipe_data_in;
                end
            end else begin
                dst_data_out <= mem[rd_next];
            end
        end else if (wr_en && occupancy == '0) begin
            dst_data_out <= pipe_data_in;
        end
    end

`ifdef PIPE_CREDIT_SINK_ERR_EN
    logic       overflow;
    logic       underflow;
    logic [1:0] err_q;

    assign overflow  = pipe_valid_in && full && !pop;
    assign underflow = pipe_valid_in && !accept && inflight == '0;

    // Sticky protocol-error flags {underflow, overflow}; only reset clears them.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_q | {underflow, overflow};
        end
    end

    assign err_out = err_q;
`else
    assign err_out = 2'b00;
`endif

endmodule

// File: tb/tb_pipe_credit_sink.sv
// tb/tb_pipe_credit_sink.sv - scoreboard bench for pipe_credit_sink with a delay-line pipeline model
module tb_pipe_credit_sink;

    localparam int DW    = 16;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic                 clk;
    logic                 arst_n;
    logic                 src_valid_in;
    logic                 src_ready_out;
    logic signed [DW-1:0] pipe_data_in;
    logic                 pipe_valid_in;
    logic signed [DW-1:0] dst_data_out;
    logic                 dst_valid_out;
    logic                 dst_ready_in;
    logic [LW-1:0]        level_out;
    logic [1:0]           err_out;

    pipe_credit_sink #(
        .DATA_WIDTH(DW),
        .LATENCY   (LAT),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .src_valid_in (src_valid_in),
        .src_ready_out(src_ready_out),
        .pipe_data_in (pipe_data_in),
        .pipe_valid_in(pipe_valid_in),
        .dst_data_out (dst_data_out),
        .dst_valid_out(dst_valid_out),
        .dst_ready_in (dst_ready_in),
        .level_out    (level_out),
        .err_out      (err_out)
    );

    typedef struct {
        bit                   v;
        logic signed [DW-1:0] d;
    } slot_t;

    slot_t                lane[$];
    logic signed [DW-1:0] exp_q[$];
    int                   m_occ;
    int                   m_inf;
    bit [1:0]             m_err;
    int                   n_chk;
    int                   n_err;
    int                   acc_cnt;
    logic signed [DW-1:0] next_data;
    bit                   rand_data;
    logic signed [DW-1:0] mon_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_err();
`ifdef PIPE_CREDIT_SINK_ERR_EN
        return int'(m_err);
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        slot_t s;
        lane.delete();
        s.v = 1'b0;
        s.d = '0;
        for (int i = 0; i < LAT; i++) lane.push_back(s);
        exp_q.delete();
        m_occ = 0;
        m_inf = 0;
        m_err = 2'b00;
    endtask

    task automatic apply_reset();
        arst_n        = 1'b0;
        src_valid_in  = 1'b0;
        dst_ready_in  = 1'b0;
        pipe_valid_in = 1'b0;
        pipe_data_in  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: check registered state, drive inputs, advance the reference model.
    task automatic step(input bit sv, input bit dr, input bit fpv, input logic signed [DW-1:0] fd);
        slot_t                s;
        bit                   rdy;
        bit                   acc;
        bit                   pv;
        bit                   pp;
        int                   occ0;
        logic signed [DW-1:0] pd;
        occ0 = m_occ;
        rdy  = (m_occ + m_inf) < DEPTH;
        chk("level", int'(level_out), m_occ);
        chk("src_ready", int'(src_ready_out), int'(rdy));
        chk("dst_valid", int'(dst_valid_out), int'(m_occ != 0));
        chk("err", int'(err_out), exp_err());
        if (m_occ != 0) chk("head", int'(dst_data_out), int'(exp_q[0]));
        s  = lane.pop_front();
        pv = s.v;
        pd = s.d;
        if (fpv) begin
            pv = 1'b1;
            pd = fd;
        end
        src_valid_in  = sv;
        dst_ready_in  = dr;
        pipe_valid_in = pv;
        pipe_data_in  = pd;
        acc = sv && rdy;
        if (acc) acc_cnt++;
        s.v = acc;
        s.d = next_data;
        lane.push_back(s);
        if (acc) next_data = rand_data ? DW'($urandom) : next_data + 16'sd1;
        pp = (m_occ != 0) && dr;
        if (acc && !pv) m_inf++;
        else if (pv && !acc) begin
            if (m_inf == 0) m_err[1] = 1'b1;
            else m_inf--;
        end
        if (pv) begin
            if (m_occ == DEPTH && !pp) m_err[0] = 1'b1;
            else begin
                exp_q.push_back(pd);
                m_occ++;
            end
        end
        if (pp) m_occ--;
        #2;
        chk("comb_dst_valid", int'(dst_valid_out), int'(occ0 != 0));
        chk("comb_src_ready", int'(src_ready_out), int'(rdy));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every DUT pop must match the oldest expected sample.
    always @(negedge clk) begin
        if (arst_n && dst_valid_out && dst_ready_in) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL pop_unexpected: got %0d expected no output at %0t", dst_data_out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", int'(dst_data_out), int'(mon_exp));
            end
        end
    end

    initial begin
        n_chk     = 0;
        n_err     = 0;
        acc_cnt   = 0;
        rand_data = 1'b0;
        next_data = 16'sd1;
        apply_reset();

        chk("rst_dst_valid", int'(dst_valid_out), 0);
        chk("rst_dst_data", int'(dst_data_out), 0);
        chk("rst_level", int'(level_out), 0);
        chk("rst_src_ready", int'(src_ready_out), 1);
        chk("rst_err", int'(err_out), 0);

        // Reset mid-stream with two stored samples and one still in flight.
        repeat (3) step(1'b1, 1'b0, 1'b0, '0);
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);
        chk("t1_level_pre", int'(level_out), m_occ);
        chk("t1_inflight_model", m_inf, 1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("t1_dst_valid", int'(dst_valid_out), 0);
        chk("t1_level", int'(level_out), 0);
        chk("t1_src_ready", int'(src_ready_out), 1);
        chk("t1_err", int'(err_out), 0);
        chk("t1_dst_data", int'(dst_data_out), 0);
        apply_reset();

        // Continuous stream with an always-ready consumer.
        next_data = 16'sd1;
        repeat (30) step(1'b1, 1'b1, 1'b0, '0);
        repeat (8) step(1'b0, 1'b1, 1'b0, '0);

        // Consumer stall: credits must cap accepts at DEPTH.
        apply_reset();
        acc_cnt = 0;
        repeat (12) step(1'b1, 1'b0, 1'b0, '0);
        chk("t3_accepts", acc_cnt, DEPTH);
        chk("t3_level_full", int'(level_out), DEPTH);
        repeat (12) step(1'b1, 1'b1, 1'b0, '0);
        repeat (8) step(1'b0, 1'b1, 1'b0, '0);

        // Full FIFO with simultaneous pop and forced arrival.
        apply_reset();
        repeat (8) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 16'sd100);
        chk("t4_level_stays", int'(level_out), DEPTH);
        chk("t4_no_overflow", int'(err_out[0]), 0);
        step(1'b0, 1'b0, 1'b0, '0);
        repeat (8) step(1'b0, 1'b1, 1'b0, '0);

        // Protocol violations: arrival into a full FIFO, then arrival with nothing in flight.
        apply_reset();
        repeat (8) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 16'sd200);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        repeat (6) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 16'sd300);
        repeat (4) step(1'b0, 1'b1, 1'b0, '0);
        apply_reset();
        step(1'b0, 1'b0, 1'b0, '0);

        // Single sample into an empty FIFO: visible one cycle after its arrival.
        apply_reset();
        next_data = -16'sd5;
        step(1'b1, 1'b0, 1'b0, '0);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        chk("t6_valid", int'(dst_valid_out), 1);
        chk("t6_data", int'(dst_data_out), -5);
        repeat (2) step(1'b0, 1'b1, 1'b0, '0);

        // Randomised traffic and consumer back-pressure.
        apply_reset();
        rand_data = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0, '0);
        end
        repeat (10) step(1'b0, 1'b1, 1'b0, '0);
        chk("final_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
